// File: rtl/regfile_writeback_buffer.sv
// -----------------------------------------------------------------------------
// regfile_writeback_buffer
//
// Purpose:
//   Producer side of the register-file write port. Writeback requests come
//   from two sources:
//   - Port A is the single-cycle ALU path. It has priority and no backpressure.
//   - Port B is the multi-cycle unit, using a valid/ready handshake.
//   Requests are queued in a small FIFO. One entry retires per cycle onto the
//   register file's RegWrite/RDaddr/RDdata inputs. A two-port lookup reports
//   the youngest pending write for each of two addresses, so that decode can
//   forward values that have not yet been retired.
//
// Optional feature (macro WB_COALESCE_EN):
//   When defined, an accepted request overwrites the youngest entry's data in
//   place if both of these hold:
//   - the request's address equals the youngest entry's address;
//   - that entry is not the head (count >= 2).
//   When undefined, every accepted non-zero request allocates a new entry.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2)
//   DATA_W  write data width
//   ADDR_W  register address width
//
// Ports:
//   clk_i                  clock, all state updates on the rising edge
//   rst_i                  asynchronous active-low reset
//   A_valid_i/addr/data    ALU writeback request (priority)
//   B_valid_i/addr/data    multi-cycle unit request
//   B_ready_o              B request accepted this cycle when high with valid
//   stall_o                upstream must hold ALU issue (count >= DEPTH-1)
//   overflow_o             sticky: an A request was lost while full
//   RegWrite_o             register file write enable (head valid)
//   RDaddr_o / RDdata_o    head entry address / data (0 when empty)
//   RSaddr_i / RTaddr_i    lookup addresses
//   RShit_o / RSdata_o     pending-write hit / youngest data for RSaddr_i
//   RThit_o / RTdata_o     pending-write hit / youngest data for RTaddr_i
// -----------------------------------------------------------------------------
module regfile_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              A_valid_i,
    input  logic [ADDR_W-1:0] A_addr_i,
    input  logic [DATA_W-1:0] A_data_i,
    input  logic              B_valid_i,
    input  logic [ADDR_W-1:0] B_addr_i,
    input  logic [DATA_W-1:0] B_data_i,
    output logic              B_ready_o,
    output logic              stall_o,
    output logic              overflow_o,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic              RShit_o,
    output logic [DATA_W-1:0] RSdata_o,
    output logic              RThit_o,
    output logic [DATA_W-1:0] RTdata_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);

    // FIFO storage and pointers
    logic [ADDR_W-1:0] addrMem_q [DEPTH];
    logic [DATA_W-1:0] dataMem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    // Enqueue/dequeue decision signals
    logic              full;
    logic              deq;
    logic              aAccept;
    logic              bAccept;
    logic              enqValid;
    logic [ADDR_W-1:0] enqAddr;
    logic [DATA_W-1:0] enqData;
    logic              store;
    logic              coalesce;
    logic              memWe;
    logic [PTR_W-1:0]  memIdx;

    assign full = (count_q == CNT_FULL);
    assign deq  = (count_q != '0);

    // Port selection and FIFO bookkeeping for the next edge.
    // A may enter while full only when the head retires on the same edge.
    // B is offered a slot only when the buffer is not full and A is idle.
    always_comb begin
        aAccept    = A_valid_i && (!full || deq);
        bAccept    = B_valid_i && !full && !A_valid_i;
        enqValid   = aAccept || bAccept;
        enqAddr    = aAccept ? A_addr_i : B_addr_i;
        enqData    = aAccept ? A_data_i : B_data_i;
        overflow_d = overflow_q || (A_valid_i && full && !deq);

`ifdef WB_COALESCE_EN
        // The youngest entry can only be merged when it is not the head.
        // The head may be popping on this edge.
        coalesce = enqValid && (enqAddr != '0) && (count_q >= CNT_W'(2)) &&
                   (addrMem_q[tail_q - PTR_W'(1)] == enqAddr);
`else
        coalesce = 1'b0;
`endif

        // Register 0 requests complete their handshake but are never stored
        store  = enqValid && (enqAddr != '0) && !coalesce;
        memWe  = store || coalesce;
        memIdx = coalesce ? (tail_q - PTR_W'(1)) : tail_q;

        head_d  = deq   ? (head_q + PTR_W'(1)) : head_q;
        tail_d  = store ? (tail_q + PTR_W'(1)) : tail_q;
        count_d = count_q;
        if (store && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!store && deq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers and storage.
    // Reset discards every queued entry and clears the sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addrMem_q[i] <= '0;
                dataMem_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (memWe) begin
                dataMem_q[memIdx] <= enqData;
            end
            if (store) begin
                addrMem_q[memIdx] <= enqAddr;
            end
        end
    end

    // Pending-write lookup over the valid window [head, head+count).
    // The scan runs oldest to youngest, so the last match holds the youngest data.
    always_comb begin
        RShit_o  = 1'b0;
        RSdata_o = '0;
        RThit_o  = 1'b0;
        RTdata_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if ((RSaddr_i != '0) && (addrMem_q[head_q + PTR_W'(i)] == RSaddr_i)) begin
                    RShit_o  = 1'b1;
                    RSdata_o = dataMem_q[head_q + PTR_W'(i)];
                end
                if ((RTaddr_i != '0) && (addrMem_q[head_q + PTR_W'(i)] == RTaddr_i)) begin
                    RThit_o  = 1'b1;
                    RTdata_o = dataMem_q[head_q + PTR_W'(i)];
                end
            end
        end
    end

    // Write port: stale storage is masked so an empty buffer drives zeros.
    assign RegWrite_o = deq;
    assign RDaddr_o   = deq ? addrMem_q[head_q] : '0;
    assign RDdata_o   = deq ? dataMem_q[head_q] : '0;
    assign B_ready_o  = !full && !A_valid_i;
    assign stall_o    = (count_q >= CNT_STALL);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback_buffer
//
// Self-checking bench for regfile_writeback_buffer.
// Directed scenarios are followed by a randomized run. In the randomized run,
// every cycle is compared against a queue-based reference model of the
// pending writes. Honours WB_COALESCE_EN in the model.
// -----------------------------------------------------------------------------
module tb_regfile_writeback_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk = 1'b0;
    logic              rstN;
    logic              aValid;
    logic [ADDR_W-1:0] aAddr;
    logic [DATA_W-1:0] aData;
    logic              bValid;
    logic [ADDR_W-1:0] bAddr;
    logic [DATA_W-1:0] bData;
    logic              bReady;
    logic              stall;
    logic              overflow;
    logic              regWrite;
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] rdData;
    logic [ADDR_W-1:0] rsAddr;
    logic [ADDR_W-1:0] rtAddr;
    logic              rsHit;
    logic [DATA_W-1:0] rsData;
    logic              rtHit;
    logic [DATA_W-1:0] rtData;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: pending writes, oldest at the front
    entry_t model[$];
    logic   modelOverflow;

    always #5 clk = ~clk;

    regfile_writeback_buffer #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rstN),
        .A_valid_i (aValid),
        .A_addr_i  (aAddr),
        .A_data_i  (aData),
        .B_valid_i (bValid),
        .B_addr_i  (bAddr),
        .B_data_i  (bData),
        .B_ready_o (bReady),
        .stall_o   (stall),
        .overflow_o(overflow),
        .RegWrite_o(regWrite),
        .RDaddr_o  (rdAddr),
        .RDdata_o  (rdData),
        .RSaddr_i  (rsAddr),
        .RTaddr_i  (rtAddr),
        .RShit_o   (rsHit),
        .RSdata_o  (rsData),
        .RThit_o   (rtHit),
        .RTdata_o  (rtData)
    );

    // Drive all request and lookup inputs for the current cycle
    task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] aa,
                                 input logic [DATA_W-1:0] ad, input logic bv,
                                 input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                                 input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
        aValid = av; aAddr = aa; aData = ad;
        bValid = bv; bAddr = ba; bData = bd;
        rsAddr = rs; rtAddr = rt;
    endtask

    // Model: apply one clock edge using the inputs currently driven
    task automatic modelStep();
        bit                popped;
        bit                isFull;
        bit                aTake;
        bit                bTake;
        bit                merged;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        entry_t            e;
        popped = (model.size() != 0);
        isFull = (model.size() == DEPTH);
        aTake  = aValid && (!isFull || popped);
        bTake  = bValid && !isFull && !aValid;
        if (aValid && isFull && !popped) modelOverflow = 1'b1;
        addr   = aTake ? aAddr : bAddr;
        data   = aTake ? aData : bData;
        merged = 1'b0;
`ifdef WB_COALESCE_EN
        if ((aTake || bTake) && addr != 0 && model.size() >= 2 &&
            model[model.size()-1].addr == addr) begin
            e = model[model.size()-1];
            e.data = data;
            model[model.size()-1] = e;
            merged = 1'b1;
        end
`endif
        if (popped) void'(model.pop_front());
        if ((aTake || bTake) && addr != 0 && !merged) begin
            e.addr = addr;
            e.data = data;
            model.push_back(e);
        end
    endtask

    // Model lookup: the youngest matching pending write, never for register 0
    task automatic modelLookup(input logic [ADDR_W-1:0] a, output logic hit,
                               output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            foreach (model[i]) begin
                if (model[i].addr == a) begin
                    hit = 1'b1;
                    d   = model[i].data;
                end
            end
        end
    endtask

    // Advance one cycle, stepping the model on the edge
    task automatic clockEdge();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rstN = 1'b0;
        model.delete();
        modelOverflow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);
        rstN = 1'b0;
        model.delete();
        modelOverflow = 1'b0;
        #1;
        testsRun++;
        if ({regWrite, rdAddr, rdData, stall, overflow, rsHit, rtHit, rsData, rtData} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got regWrite=%0b rdAddr=%0d rdData=%h stall=%0b ovf=%0b rsHit=%0b rtHit=%0b, expected all 0",
                     regWrite, rdAddr, rdData, stall, overflow, rsHit, rtHit);
        end
        testsRun++;
        if (bReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_bready: got %0b expected 1", bReady);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_a();
        applyStimulus(1, 3, 32'h11, 0, 0, 0, 0, 0);
        #1;
        testsRun++;
        if (regWrite !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_no_bypass: regWrite got %0b expected 0", regWrite);
        end
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        testsRun++;
        if (regWrite !== 1'b1 || rdAddr !== 5'd3 || rdData !== 32'h11) begin
            testsFailed++;
            $display("[TB] FAIL single_retire: got we=%0b addr=%0d data=%h expected we=1 addr=3 data=11",
                     regWrite, rdAddr, rdData);
        end
        clockEdge();
        #1;
        testsRun++;
        if (regWrite !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_drained: regWrite got %0b expected 0", regWrite);
        end
    endtask

    task automatic test_priority();
        applyStimulus(1, 4, 32'hA, 1, 5, 32'hB, 0, 0);
        #1;
        testsRun++;
        if (bReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL prio_bready_low: got %0b expected 0", bReady);
        end
        clockEdge();
        applyStimulus(0, 0, 0, 1, 5, 32'hB, 0, 0);
        #1;
        testsRun++;
        if (bReady !== 1'b1 || regWrite !== 1'b1 || rdAddr !== 5'd4 || rdData !== 32'hA) begin
            testsFailed++;
            $display("[TB] FAIL prio_first: got ready=%0b we=%0b addr=%0d data=%h expected 1 1 4 a",
                     bReady, regWrite, rdAddr, rdData);
        end
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        testsRun++;
        if (regWrite !== 1'b1 || rdAddr !== 5'd5 || rdData !== 32'hB) begin
            testsFailed++;
            $display("[TB] FAIL prio_second: got we=%0b addr=%0d data=%h expected 1 5 b",
                     regWrite, rdAddr, rdData);
        end
        clockEdge();
        #1;
        testsRun++;
        if (regWrite !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL prio_drained: regWrite got %0b expected 0", regWrite);
        end
    endtask

    task automatic test_addr_zero();
        applyStimulus(1, 0, 32'hFF, 0, 0, 0, 0, 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        testsRun++;
        if (regWrite !== 1'b0 || rsHit !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL addr_zero: got we=%0b rsHit=%0b expected 0 0", regWrite, rsHit);
        end
        applyStimulus(0, 0, 0, 1, 0, 32'hFF, 0, 0);
        #1;
        testsRun++;
        if (bReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL addr_zero_b_ready: got %0b expected 1", bReady);
        end
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        testsRun++;
        if (regWrite !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL addr_zero_b: regWrite got %0b expected 0", regWrite);
        end
    endtask

    task automatic test_same_addr();
        applyStimulus(1, 7, 32'h1, 0, 0, 0, 7, 7);
        clockEdge();
        applyStimulus(1, 7, 32'h2, 0, 0, 0, 7, 7);
        #1;
        testsRun++;
        if (rsHit !== 1'b1 || rsData !== 32'h1 || rdData !== 32'h1) begin
            testsFailed++;
            $display("[TB] FAIL same_addr_first: got hit=%0b data=%h rd=%h expected 1 1 1", rsHit, rsData, rdData);
        end
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 7, 7);
        #1;
        testsRun++;
        if (rsHit !== 1'b1 || rsData !== 32'h2 || rtData !== 32'h2 || regWrite !== 1'b1 || rdData !== 32'h2) begin
            testsFailed++;
            $display("[TB] FAIL same_addr_second: got hit=%0b rs=%h rt=%h we=%0b rd=%h expected 1 2 2 1 2",
                     rsHit, rsData, rtData, regWrite, rdData);
        end
        clockEdge();
        #1;
        testsRun++;
        if (regWrite !== 1'b0 || rsHit !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL same_addr_drained: got we=%0b hit=%0b expected 0 0", regWrite, rsHit);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 5'(i), 32'(i * 16), 1, 9, 32'hDEAD, 0, 0);
            #1;
            testsRun++;
            if (bReady !== 1'b0 || stall !== 1'b0 || overflow !== 1'b0 ||
                regWrite !== (i > 1) || rdData !== ((i > 1) ? 32'((i - 1) * 16) : 32'h0)) begin
                testsFailed++;
                $display("[TB] FAIL back_to_back[%0d]: got ready=%0b stall=%0b ovf=%0b we=%0b rd=%h",
                         i, bReady, stall, overflow, regWrite, rdData);
            end
            clockEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        clockEdge();
    endtask

    task automatic test_reset_mid();
        applyStimulus(1, 6, 32'h66, 0, 0, 0, 6, 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 6, 0);
        #2;
        rstN = 1'b0;
        model.delete();
        modelOverflow = 1'b0;
        #1;
        testsRun++;
        if (regWrite !== 1'b0 || rsHit !== 1'b0 || rdData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_async: got we=%0b hit=%0b rd=%h expected 0 0 0", regWrite, rsHit, rdData);
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clockEdge();
            #1;
            testsRun++;
            if (regWrite !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_retire[%0d]: regWrite got %0b expected 0", i, regWrite);
            end
        end
    endtask

    task automatic test_random();
        logic              expHit;
        logic [DATA_W-1:0] expData;
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            testsRun++;
            if (regWrite !== (model.size() != 0) ||
                rdAddr !== ((model.size() != 0) ? model[0].addr : 5'd0) ||
                rdData !== ((model.size() != 0) ? model[0].data : 32'd0)) begin
                testsFailed++;
                $display("[TB] FAIL rand_port[%0d]: got we=%0b addr=%0d data=%h, model size=%0d",
                         c, regWrite, rdAddr, rdData, model.size());
            end
            testsRun++;
            if (bReady !== (model.size() != DEPTH && !aValid) ||
                stall !== (model.size() >= DEPTH - 1) || overflow !== modelOverflow) begin
                testsFailed++;
                $display("[TB] FAIL rand_flags[%0d]: got ready=%0b stall=%0b ovf=%0b expected ovf=%0b size=%0d",
                         c, bReady, stall, overflow, modelOverflow, model.size());
            end
            modelLookup(rsAddr, expHit, expData);
            testsRun++;
            if (rsHit !== expHit || rsData !== expData) begin
                testsFailed++;
                $display("[TB] FAIL rand_rs[%0d]: got hit=%0b data=%h expected hit=%0b data=%h",
                         c, rsHit, rsData, expHit, expData);
            end
            modelLookup(rtAddr, expHit, expData);
            testsRun++;
            if (rtHit !== expHit || rtData !== expData) begin
                testsFailed++;
                $display("[TB] FAIL rand_rt[%0d]: got hit=%0b data=%h expected hit=%0b data=%h",
                         c, rtHit, rtData, expHit, expData);
            end
            clockEdge();
        end
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        model.delete();
        modelOverflow = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_a();
        test_priority();
        test_addr_zero();
        test_same_addr();
        test_back_to_back();
        test_reset_mid();
        doReset();
        @(negedge clk);
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
